// File: rtl/char_hp_tracker.sv
// Player hit-point tracker: loads class HP, applies damage, runs invulnerability/blink, flags death.
// Optional HP regeneration is built only when CHAR_HP_REGEN_EN is defined.
module char_hp_tracker #(
    parameter int MAX_HP        = 10,
    parameter int INVULN_FRAMES = 60,
    parameter int BLINK_SHIFT   = 2,
    parameter int REGEN_FRAMES  = 300
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] game_active,
    input  logic [1:0] char_class,
    input  logic [3:0] char_hp,
    input  logic       frame_tick,
    input  logic       dmg_valid,
    input  logic [3:0] dmg_amount,
    output logic [3:0] hp_cur,
    output logic       player_dead,
    output logic       invuln,
    output logic       hit_pulse,
    output logic       char_visible
);

    localparam int              INV_W    = $clog2(INVULN_FRAMES + 1);
    localparam int              BLK_W    = BLINK_SHIFT + 1;
    localparam logic [3:0]      HP_CAP   = 4'(MAX_HP);
    localparam logic [INV_W-1:0] INV_LOAD = INV_W'(INVULN_FRAMES);

    // HP is a 4-bit quantity; reject configurations that cannot be represented.
    if (MAX_HP < 1 || MAX_HP > 15 || INVULN_FRAMES < 1 || BLINK_SHIFT < 0 || REGEN_FRAMES < 1) begin : g_bad_params
        $error("char_hp_tracker: parameter out of range");
    end

    typedef enum logic [1:0] {IDLE, ALIVE, INVULN, DEAD} state_t;

    state_t           state;
    logic [INV_W-1:0] inv_cnt;
    logic [BLK_W-1:0] blink_cnt;
    logic [BLK_W-1:0] blink_next;
    logic [3:0]       load_hp;
    logic [4:0]       dmg_diff;
    logic [3:0]       hp_after_hit;

`ifdef CHAR_HP_REGEN_EN
    localparam int               REG_W     = $clog2(REGEN_FRAMES + 1);
    localparam logic [REG_W-1:0] REG_LIMIT = REG_W'(REGEN_FRAMES);

    logic [REG_W-1:0] regen_cnt;
    logic [REG_W-1:0] regen_next;
    logic [3:0]       hp_max;

    assign regen_next = regen_cnt + 1'b1;
`endif

    assign load_hp      = (char_hp > HP_CAP) ? HP_CAP : char_hp;
    // A borrow out of the 5-bit difference means the hit exceeded the remaining HP.
    assign dmg_diff     = {1'b0, hp_cur} - {1'b0, dmg_amount};
    assign hp_after_hit = dmg_diff[4] ? 4'd0 : dmg_diff[3:0];
    assign blink_next   = blink_cnt + 1'b1;

    always_ff @(posedge clk) begin
        if (rst || game_active == 2'd0) begin
            state        <= IDLE;
            hp_cur       <= 4'd0;
            player_dead  <= 1'b0;
            invuln       <= 1'b0;
            hit_pulse    <= 1'b0;
            char_visible <= 1'b1;
            inv_cnt      <= '0;
            blink_cnt    <= '0;
`ifdef CHAR_HP_REGEN_EN
            regen_cnt    <= '0;
            hp_max       <= 4'd0;
`endif
        end else if (game_active[1]) begin
            // Frozen (game over / paused): everything holds, only the pulse retires.
            hit_pulse <= 1'b0;
        end else begin
            hit_pulse <= 1'b0;
            case (state)
                IDLE: begin
                    if (char_class != 2'd0) begin
                        hp_cur <= load_hp;
`ifdef CHAR_HP_REGEN_EN
                        hp_max <= load_hp;
`endif
                        if (load_hp == 4'd0) begin
                            state       <= DEAD;
                            player_dead <= 1'b1;
                        end else begin
                            state <= ALIVE;
                        end
                    end
                end

                ALIVE: begin
                    if (dmg_valid) begin
                        // A simultaneous frame_tick is swallowed by the full reload below.
                        hp_cur    <= hp_after_hit;
                        hit_pulse <= 1'b1;
`ifdef CHAR_HP_REGEN_EN
                        regen_cnt <= '0;
`endif
                        if (hp_after_hit == 4'd0) begin
                            state       <= DEAD;
                            player_dead <= 1'b1;
                        end else begin
                            state        <= INVULN;
                            invuln       <= 1'b1;
                            inv_cnt      <= INV_LOAD;
                            blink_cnt    <= '0;
                            char_visible <= 1'b1;
                        end
                    end
`ifdef CHAR_HP_REGEN_EN
                    else if (frame_tick) begin
                        if (regen_next == REG_LIMIT) begin
                            regen_cnt <= '0;
                            if (hp_cur < hp_max) begin
                                hp_cur <= hp_cur + 4'd1;
                            end
                        end else begin
                            regen_cnt <= regen_next;
                        end
                    end
`endif
                end

                INVULN: begin
                    if (frame_tick) begin
                        inv_cnt   <= inv_cnt - 1'b1;
                        blink_cnt <= blink_next;
                        if (inv_cnt == INV_W'(1)) begin
                            state        <= ALIVE;
                            invuln       <= 1'b0;
                            char_visible <= 1'b1;
                        end else begin
                            char_visible <= ~blink_next[BLINK_SHIFT];
                        end
                    end
                end

                DEAD: begin
                    hp_cur      <= 4'd0;
                    player_dead <= 1'b1;
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_char_hp_tracker.sv
// Directed bench for char_hp_tracker: a vector table for single-cycle behaviour plus
// hand sequences for invulnerability timing, blink, freeze, reset and regeneration.
module tb_char_hp_tracker;

    localparam int BS = 2;

    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] game_active;
    logic [1:0] char_class;
    logic [3:0] char_hp;
    logic       frame_tick;
    logic       dmg_valid;
    logic [3:0] dmg_amount;
    logic [3:0] hp_cur;
    logic       player_dead;
    logic       invuln;
    logic       hit_pulse;
    logic       char_visible;

    int n_pass  = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    char_hp_tracker #(
        .MAX_HP       (10),
        .INVULN_FRAMES(60),
        .BLINK_SHIFT  (BS),
        .REGEN_FRAMES (300)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .game_active (game_active),
        .char_class  (char_class),
        .char_hp     (char_hp),
        .frame_tick  (frame_tick),
        .dmg_valid   (dmg_valid),
        .dmg_amount  (dmg_amount),
        .hp_cur      (hp_cur),
        .player_dead (player_dead),
        .invuln      (invuln),
        .hit_pulse   (hit_pulse),
        .char_visible(char_visible)
    );

    typedef struct {
        logic       r;
        logic [1:0] ga;
        logic [1:0] cls;
        logic [3:0] hp;
        logic       tk;
        logic       dv;
        logic [3:0] amt;
        logic [3:0] e_hp;
        logic       e_dead;
        logic       e_inv;
        logic       e_hit;
        logic       e_vis;
    } vec_t;

    vec_t tbl[23];

    // Apply one cycle of inputs, then sample just after the edge.
    task automatic drive(input logic r, input logic [1:0] ga, input logic [1:0] cls,
                         input logic [3:0] hp, input logic tk, input logic dv,
                         input logic [3:0] amt);
        rst         = r;
        game_active = ga;
        char_class  = cls;
        char_hp     = hp;
        frame_tick  = tk;
        dmg_valid   = dv;
        dmg_amount  = amt;
        @(posedge clk);
        #1;
    endtask

    task automatic play(input logic tk, input logic dv, input logic [3:0] amt);
        drive(1'b0, 2'd1, 2'd1, 4'd10, tk, dv, amt);
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) play(1'b1, 1'b0, 4'd0);
    endtask

    task automatic check(input string name, input logic [3:0] ehp, input logic ed,
                         input logic ei, input logic eh, input logic ev);
        n_total++;
        if ({hp_cur, player_dead, invuln, hit_pulse, char_visible} === {ehp, ed, ei, eh, ev})
            n_pass++;
        else
            $display("FAIL %s: got hp=%0d dead=%b inv=%b hit=%b vis=%b, expected hp=%0d dead=%b inv=%b hit=%b vis=%b",
                     name, hp_cur, player_dead, invuln, hit_pulse, char_visible, ehp, ed, ei, eh, ev);
    endtask

    // Visibility after k ticks of invulnerability (blink counter = k, wrapping).
    function automatic logic vis_at(input int k);
        return ((k >> BS) & 1) == 0;
    endfunction

    initial begin
        //           r   ga    cls   hp     tk  dv  amt    e_hp   dead inv  hit  vis
        tbl[0]  = '{1'b1, 2'd0, 2'd0, 4'd0,  1'b0, 1'b0, 4'd0,  4'd0,  1'b0, 1'b0, 1'b0, 1'b1};
        tbl[1]  = '{1'b0, 2'd0, 2'd1, 4'd10, 1'b0, 1'b0, 4'd0,  4'd0,  1'b0, 1'b0, 1'b0, 1'b1};
        tbl[2]  = '{1'b0, 2'd1, 2'd1, 4'd10, 1'b0, 1'b0, 4'd0,  4'd10, 1'b0, 1'b0, 1'b0, 1'b1};
        tbl[3]  = '{1'b0, 2'd1, 2'd1, 4'd10, 1'b0, 1'b1, 4'd3,  4'd7,  1'b0, 1'b1, 1'b1, 1'b1};
        tbl[4]  = '{1'b0, 2'd1, 2'd1, 4'd10, 1'b0, 1'b0, 4'd0,  4'd7,  1'b0, 1'b1, 1'b0, 1'b1};
        tbl[5]  = '{1'b0, 2'd1, 2'd1, 4'd10, 1'b0, 1'b1, 4'd5,  4'd7,  1'b0, 1'b1, 1'b0, 1'b1};
        tbl[6]  = '{1'b0, 2'd0, 2'd1, 4'd10, 1'b0, 1'b0, 4'd0,  4'd0,  1'b0, 1'b0, 1'b0, 1'b1};
        tbl[7]  = '{1'b0, 2'd1, 2'd2, 4'd5,  1'b0, 1'b0, 4'd0,  4'd5,  1'b0, 1'b0, 1'b0, 1'b1};
        tbl[8]  = '{1'b0, 2'd1, 2'd2, 4'd5,  1'b0, 1'b1, 4'd7,  4'd0,  1'b1, 1'b0, 1'b1, 1'b1};
        tbl[9]  = '{1'b0, 2'd1, 2'd2, 4'd5,  1'b0, 1'b1, 4'd2,  4'd0,  1'b1, 1'b0, 1'b0, 1'b1};
        tbl[10] = '{1'b0, 2'd0, 2'd2, 4'd5,  1'b0, 1'b0, 4'd0,  4'd0,  1'b0, 1'b0, 1'b0, 1'b1};
        tbl[11] = '{1'b0, 2'd1, 2'd0, 4'd5,  1'b0, 1'b0, 4'd0,  4'd0,  1'b0, 1'b0, 1'b0, 1'b1};
        tbl[12] = '{1'b0, 2'd1, 2'd3, 4'd15, 1'b0, 1'b0, 4'd0,  4'd10, 1'b0, 1'b0, 1'b0, 1'b1};
        tbl[13] = '{1'b0, 2'd1, 2'd3, 4'd15, 1'b1, 1'b1, 4'd0,  4'd10, 1'b0, 1'b1, 1'b1, 1'b1};
        tbl[14] = '{1'b0, 2'd3, 2'd3, 4'd15, 1'b1, 1'b1, 4'd4,  4'd10, 1'b0, 1'b1, 1'b0, 1'b1};
        tbl[15] = '{1'b0, 2'd0, 2'd3, 4'd15, 1'b0, 1'b0, 4'd0,  4'd0,  1'b0, 1'b0, 1'b0, 1'b1};
        tbl[16] = '{1'b0, 2'd1, 2'd1, 4'd0,  1'b0, 1'b0, 4'd0,  4'd0,  1'b1, 1'b0, 1'b0, 1'b1};
        tbl[17] = '{1'b0, 2'd0, 2'd1, 4'd0,  1'b0, 1'b0, 4'd0,  4'd0,  1'b0, 1'b0, 1'b0, 1'b1};
        tbl[18] = '{1'b0, 2'd1, 2'd1, 4'd4,  1'b0, 1'b0, 4'd0,  4'd4,  1'b0, 1'b0, 1'b0, 1'b1};
        tbl[19] = '{1'b0, 2'd1, 2'd1, 4'd4,  1'b0, 1'b1, 4'd15, 4'd0,  1'b1, 1'b0, 1'b1, 1'b1};
        tbl[20] = '{1'b1, 2'd1, 2'd1, 4'd4,  1'b0, 1'b0, 4'd0,  4'd0,  1'b0, 1'b0, 1'b0, 1'b1};
        tbl[21] = '{1'b0, 2'd1, 2'd1, 4'd4,  1'b0, 1'b0, 4'd0,  4'd4,  1'b0, 1'b0, 1'b0, 1'b1};
        tbl[22] = '{1'b0, 2'd0, 2'd1, 4'd4,  1'b0, 1'b0, 4'd0,  4'd0,  1'b0, 1'b0, 1'b0, 1'b1};

        for (int i = 0; i < 23; i++) begin
            drive(tbl[i].r, tbl[i].ga, tbl[i].cls, tbl[i].hp, tbl[i].tk, tbl[i].dv, tbl[i].amt);
            check($sformatf("vec%0d", i), tbl[i].e_hp, tbl[i].e_dead, tbl[i].e_inv,
                  tbl[i].e_hit, tbl[i].e_vis);
        end

        // Invulnerability window, blink pattern, and damage dropped on the final tick.
        play(1'b0, 1'b0, 4'd0);
        check("win_load", 4'd10, 1'b0, 1'b0, 1'b0, 1'b1);
        play(1'b0, 1'b1, 4'd3);
        check("win_hit", 4'd7, 1'b0, 1'b1, 1'b1, 1'b1);
        for (int k = 1; k <= 60; k++) begin
            play(1'b1, (k == 30) || (k == 60), (k == 30) ? 4'd5 : 4'd1);
            if (k < 60)
                check($sformatf("win_tick%0d", k), 4'd7, 1'b0, 1'b1, 1'b0, vis_at(k));
            else
                check("win_end", 4'd7, 1'b0, 1'b0, 1'b0, 1'b1);
        end
        play(1'b0, 1'b1, 4'd5);
        check("win_rehit", 4'd2, 1'b0, 1'b1, 1'b1, 1'b1);
        play(1'b0, 1'b0, 4'd0);
        check("win_pulse_off", 4'd2, 1'b0, 1'b1, 1'b0, 1'b1);

        // Freeze holds the invulnerability counter; resumes with 20 ticks left.
        drive(1'b0, 2'd0, 2'd1, 4'd10, 1'b0, 1'b0, 4'd0);
        check("frz_idle", 4'd0, 1'b0, 1'b0, 1'b0, 1'b1);
        play(1'b0, 1'b0, 4'd0);
        play(1'b0, 1'b1, 4'd1);
        check("frz_hit", 4'd9, 1'b0, 1'b1, 1'b1, 1'b1);
        ticks(40);
        check("frz_40", 4'd9, 1'b0, 1'b1, 1'b0, vis_at(40));
        for (int i = 0; i < 10; i++) begin
            drive(1'b0, (i == 7) ? 2'd3 : 2'd2, 2'd1, 4'd10, 1'b1, (i == 5), 4'd4);
            check($sformatf("frz_hold%0d", i), 4'd9, 1'b0, 1'b1, 1'b0, vis_at(40));
        end
        ticks(19);
        check("frz_59", 4'd9, 1'b0, 1'b1, 1'b0, vis_at(59));
        ticks(1);
        check("frz_60", 4'd9, 1'b0, 1'b0, 1'b0, 1'b1);

        // Reset mid-INVULN and mid-DEAD.
        play(1'b0, 1'b1, 4'd2);
        ticks(5);
        check("rst_pre", 4'd7, 1'b0, 1'b1, 1'b0, vis_at(5));
        drive(1'b1, 2'd1, 2'd1, 4'd10, 1'b1, 1'b1, 4'd1);
        check("rst_inv", 4'd0, 1'b0, 1'b0, 1'b0, 1'b1);
        play(1'b0, 1'b0, 4'd0);
        check("rst_reload", 4'd10, 1'b0, 1'b0, 1'b0, 1'b1);
        play(1'b0, 1'b1, 4'd12);
        check("rst_dead_pre", 4'd0, 1'b1, 1'b0, 1'b1, 1'b1);
        drive(1'b1, 2'd1, 2'd1, 4'd10, 1'b0, 1'b0, 4'd0);
        check("rst_dead", 4'd0, 1'b0, 1'b0, 1'b0, 1'b1);

        // Regeneration (or its absence in the default build).
        drive(1'b0, 2'd0, 2'd1, 4'd10, 1'b0, 1'b0, 4'd0);
        play(1'b0, 1'b0, 4'd0);
        play(1'b0, 1'b1, 4'd3);
        ticks(60);
        check("rg_alive", 4'd7, 1'b0, 1'b0, 1'b0, 1'b1);
`ifdef CHAR_HP_REGEN_EN
        ticks(299);
        check("rg_299", 4'd7, 1'b0, 1'b0, 1'b0, 1'b1);
        ticks(1);
        check("rg_300", 4'd8, 1'b0, 1'b0, 1'b0, 1'b1);
        ticks(150);
        play(1'b0, 1'b1, 4'd1);
        check("rg_hit", 4'd7, 1'b0, 1'b1, 1'b1, 1'b1);
        ticks(60);
        ticks(299);
        check("rg_restart299", 4'd7, 1'b0, 1'b0, 1'b0, 1'b1);
        ticks(1);
        check("rg_restart300", 4'd8, 1'b0, 1'b0, 1'b0, 1'b1);
        ticks(300);
        check("rg_9", 4'd9, 1'b0, 1'b0, 1'b0, 1'b1);
        ticks(300);
        check("rg_10", 4'd10, 1'b0, 1'b0, 1'b0, 1'b1);
        ticks(300);
        check("rg_cap", 4'd10, 1'b0, 1'b0, 1'b0, 1'b1);
`else
        ticks(700);
        check("rg_none", 4'd7, 1'b0, 1'b0, 1'b0, 1'b1);
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/char_hp_tracker.md
# char_hp_tracker

Tracks the player character's live hit points during gameplay. It sits directly downstream of the class selection stage: it loads the class's starting HP (`char_hp`, `char_class`) when play begins, then applies damage events from the boss/projectile logic. It enforces frame-counted invulnerability after each hit and flags player death to the game-state controller. It also drives a blink-visibility signal to the character draw stage.

## Interface
- `MAX_HP`, default 10: hard cap on loaded and regenerated HP.
- `INVULN_FRAMES`, default 60: length of post-hit invulnerability, counted in frames.
- `BLINK_SHIFT`, default 2: during invulnerability, visibility toggles every 2^BLINK_SHIFT frames.
- `REGEN_FRAMES`, default 300: frames per +1 HP regeneration (used only with the regen macro).

Ports:
- `clk` in 1: system clock.
- `rst` in 1: reset, synchronous, active-high. Clock is `clk`.
- `game_active` in 2: game state. 0 = class select, 1 = playing, 2 = game over / frozen, 3 = treated as 2.
- `char_class` in 2: selected class. 0 = none.
- `char_hp` in 4: starting HP for the selected class.
- `frame_tick` in 1: one-cycle pulse, once per video frame.
- `dmg_valid` in 1: one-cycle damage strobe.
- `dmg_amount` in 4: damage value, sampled when `dmg_valid`=1.
- `hp_cur` out 4: current HP.
- `player_dead` out 1: high while in DEAD.
- `invuln` out 1: high while in INVULN.
- `hit_pulse` out 1: one-cycle pulse on each accepted hit.
- `char_visible` out 1: sprite enable for the draw stage.

## Operation
- States: IDLE, ALIVE, INVULN, DEAD.
- IDLE:
  - Outputs are held at `hp_cur`=0 and `char_visible`=1.
  - When `game_active`=1 and `char_class`≠0, load `hp_cur` = min(`char_hp`, `MAX_HP`).
  - If the loaded value is 0, go to DEAD. Otherwise go to ALIVE.
  - The loaded value is also latched as `hp_max`, the regeneration ceiling.
- ALIVE:
  - When `dmg_valid`=1, set `hp_cur` = `hp_cur` − `dmg_amount`, saturating at 0, and assert `hit_pulse`.
  - If the result is 0, go to DEAD. Otherwise go to INVULN with `inv_cnt` = `INVULN_FRAMES`.
  - `dmg_amount`=0 with `dmg_valid`=1 still counts as a hit: pulse and enter INVULN.
- INVULN:
  - `dmg_valid` is ignored.
  - Each `frame_tick` decrements `inv_cnt`. When a tick takes `inv_cnt` from 1 to 0, go to ALIVE on the next edge.
  - `char_visible` = ~`blink_cnt`[`BLINK_SHIFT`]. `blink_cnt` clears on INVULN entry and increments on each `frame_tick`.
- DEAD:
  - `player_dead`=1 and `hp_cur`=0.
  - Stay in DEAD until `game_active`=0.
- Global transitions:
  - `game_active`=0 from any state: go to IDLE next cycle and clear all counters.
  - `game_active`∈{2,3}: freeze. No damage applied, counters hold, state holds.
- Arithmetic:
  - Subtraction is done in 5 bits. A borrow clamps the result to 0.
  - `inv_cnt` is sized with $clog2(`INVULN_FRAMES`+1).
- Simultaneous events:
  - ALIVE with `dmg_valid` and `frame_tick` together: the hit is taken and `inv_cnt` loads the full `INVULN_FRAMES`; that tick is not counted.
  - INVULN final tick together with `dmg_valid`: the damage is dropped.

## Timing
- All outputs are registered and update one cycle after the sampled input.
- Latency:
  - `dmg_valid` at cycle N gives `hp_cur`, `hit_pulse`, `invuln`/`player_dead` at cycle N+1.
  - The IDLE→ALIVE load happens on the first edge with `game_active`=1 and `char_class`≠0.
- `hit_pulse` is exactly one cycle wide.
- Invulnerability lasts exactly `INVULN_FRAMES` `frame_tick` pulses.
- Reset values:
  - state = IDLE.
  - `hp_cur`=0, `player_dead`=0, `invuln`=0, `hit_pulse`=0, `char_visible`=1.
  - All counters = 0.
- Reset mid-INVULN or mid-DEAD: the next cycle is IDLE with the reset values above. The block reloads only when the load condition holds again.

## Configuration
- `CHAR_HP_REGEN_EN` defined:
  - In ALIVE, `regen_cnt` counts `frame_tick`s.
  - On reaching `REGEN_FRAMES`, `hp_cur` increments (saturating at `hp_max`) and `regen_cnt` clears.
  - `regen_cnt` clears on any accepted hit and on leaving ALIVE. It holds in the frozen state.
- `CHAR_HP_REGEN_EN` not defined:
  - No regeneration logic is built.
  - `REGEN_FRAMES` is unused and `hp_cur` never increases after load.

## Test plan
- Load and hit: `char_class`=1, `char_hp`=10, `game_active` 0→1. Expect `hp_cur`=10 next cycle. Then `dmg_valid`, `dmg_amount`=3: `hp_cur`=7, one-cycle `hit_pulse`, `invuln`=1.
- Invulnerability window: after the hit, a second `dmg_valid` (amount 5) at tick 30 is ignored (`hp_cur` stays 7). `invuln` drops exactly one cycle after the 60th `frame_tick`. A hit after that applies: `hp_cur`=2.
- Saturation and death: `char_class`=2, `char_hp`=5, `dmg_amount`=7. Expect `hp_cur`=0, `player_dead`=1, `hit_pulse`=1. Further hits change nothing. `game_active`→0 gives IDLE with `player_dead`=0.
- Freeze and reset: in INVULN with `inv_cnt`=20, set `game_active`=2 and apply 10 ticks plus a hit. State and `hp_cur` are unchanged. Assert `rst` mid-INVULN: next cycle has all outputs at reset values.
- Blink: during INVULN with `BLINK_SHIFT`=2, `char_visible` pattern per tick is 1,1,1,1,0,0,0,0,... It returns to 1 in ALIVE.
- Regen (`CHAR_HP_REGEN_EN`): `hp_cur`=7 of `hp_max` 10 in ALIVE. After 300 ticks, 8. A hit at tick 150 restarts the count. It never exceeds 10.
